alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 6-bit, 2-select ALU (ops selected by select1/select0) between two requesters. Each request is accepted with a valid/ready handshake, latched, and presented to the ALU for one cycle. The registered result is returned on a single response port, tagged with the requester ID and held until the consumer accepts it. It sits between the two datapath clients and the ALU instance, which stays external and combinational.

---
 rtl/alu_share_arbiter_if.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 82 ++++++++
 tb/tb_alu_share_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, ALU and response signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
   parameter int WIDTH = 6
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [1:0]       req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_sel1;
   logic             alu_sel0;
   logic [WIDTH-1:0] alu_res;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             busy;
   logic [7:0]       done_cnt;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_sel1, alu_sel0,
      input  alu_res,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready,
      output busy, done_cnt
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_sel1, alu_sel0,
      output alu_res,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready,
      input  busy, done_cnt
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external ALU between two requesters
module alu_share_arbiter #(
   parameter int WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             prio;
   logic             grant0;
   logic             grant1;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic [1:0]       lat_op;
   logic             lat_id;
   logic [WIDTH-1:0] res_q;
   logic [7:0]       cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // prio names the requester that wins when both are valid
   always_comb begin
      state_nx = state;
      grant0   = 1'b0;
      grant1   = 1'b0;
      case (state)
         IDLE: begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
            grant1 = bus.req1_valid && (!bus.req0_valid || prio);
            if (grant0 || grant1) state_nx = EXEC;
         end
         EXEC:    state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_a  <= '0;
         lat_b  <= '0;
         lat_op <= 2'b00;
         lat_id <= 1'b0;
         prio   <= 1'b0;
         res_q  <= '0;
         cnt    <= 8'd0;
      end else begin
         if (grant0 || grant1) begin
            lat_a  <= grant1 ? bus.req1_a  : bus.req0_a;
            lat_b  <= grant1 ? bus.req1_b  : bus.req0_b;
            lat_op <= grant1 ? bus.req1_op : bus.req0_op;
            lat_id <= grant1;
            prio   <= grant0;
         end
         if (state == EXEC) res_q <= bus.alu_res;
         if (state == RESP && bus.rsp_ready) cnt <= cnt + 8'd1;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.alu_a      = lat_a;
   assign bus.alu_b      = lat_b;
   assign bus.alu_sel1   = lat_op[1];
   assign bus.alu_sel0   = lat_op[0];
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_id     = lat_id;
   assign bus.rsp_data   = res_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done_cnt   = cnt;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed checks of alu_share_arbiter against a transaction model
module tb_alu_share_arbiter;
   localparam int W = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_share_arbiter_if #(.WIDTH(W)) bus ();
   alu_share_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   assign bus.alu_res = alu_f(bus.alu_a, bus.alu_b, {bus.alu_sel1, bus.alu_sel0});

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // transaction model: one op in flight, response due two cycles after its grant
   bit         busy_m = 1'b0;
   int         age = 0;
   bit         prio_m = 1'b0;
   logic [7:0] cnt_m = 8'd0;
   int         total_m = 0;
   bit         e0, e1;
   bit         erv;
   bit         exp_id;
   logic [W-1:0] ea, eb, ed;
   logic [1:0]   eop;
   int         glog[$];
   int         rlog_id[$];
   int         rlog_data[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_m  = 1'b0;
         age     = 0;
         prio_m  = 1'b0;
         cnt_m   = 8'd0;
         total_m = 0;
      end else begin
         e0  = !busy_m && bus.req0_valid && (!bus.req1_valid || !prio_m);
         e1  = !busy_m && bus.req1_valid && (!bus.req0_valid || prio_m);
         erv = busy_m && age >= 2;
         chk("req0_ready", int'(bus.req0_ready), int'(e0));
         chk("req1_ready", int'(bus.req1_ready), int'(e1));
         chk("busy", int'(bus.busy), int'(busy_m));
         chk("rsp_valid", int'(bus.rsp_valid), int'(erv));
         chk("done_cnt", int'(bus.done_cnt), int'(cnt_m));
         if (erv) begin
            chk("rsp_id", int'(bus.rsp_id), int'(exp_id));
            chk("rsp_data", int'(bus.rsp_data), int'(ed));
         end
         if (busy_m && age == 1) begin
            chk("alu_a", int'(bus.alu_a), int'(ea));
            chk("alu_b", int'(bus.alu_b), int'(eb));
            chk("alu_sel", int'({bus.alu_sel1, bus.alu_sel0}), int'(eop));
         end
         if (bus.req0_ready && bus.req0_valid) glog.push_back(0);
         if (bus.req1_ready && bus.req1_valid) glog.push_back(1);
         if (bus.rsp_valid && bus.rsp_ready) begin
            rlog_id.push_back(int'(bus.rsp_id));
            rlog_data.push_back(int'(bus.rsp_data));
         end
         if (e0 || e1) begin
            busy_m = 1'b1;
            age    = 1;
            exp_id = e1;
            ea     = e1 ? bus.req1_a  : bus.req0_a;
            eb     = e1 ? bus.req1_b  : bus.req0_b;
            eop    = e1 ? bus.req1_op : bus.req0_op;
            ed     = alu_f(ea, eb, eop);
            prio_m = e0;
         end else if (busy_m) begin
            if (age >= 2) begin
               if (bus.rsp_ready) begin
                  busy_m  = 1'b0;
                  cnt_m   = cnt_m + 8'd1;
                  total_m = total_m + 1;
               end
            end else begin
               age = age + 1;
            end
         end
      end
   end

   task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      int k = 0;
      bit got = 1'b0;
      @(posedge clk); #1;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end
      while (!got && k < 50) begin
         @(negedge clk);
         got = id ? bus.req1_ready : bus.req0_ready;
         k++;
      end
      chk("do_op_grant", int'(got), 1);
      @(posedge clk); #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   task automatic wait_rsps(input int n, input string name);
      int k = 0;
      while (rlog_id.size() < n && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(name, int'(rlog_id.size() >= n), 1);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   int         k;
   int         cnt0, cnt1, alt_ok;
   logic       hold_id;
   logic [W-1:0] hold_data;
   logic [7:0] cnt_before;

   initial begin
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 2'b00;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 2'b00;
      bus.rsp_ready  = 1'b0;
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_done_cnt", int'(bus.done_cnt), 0);
      chk("rst_alu_a", int'(bus.alu_a), 0);
      chk("rst_rsp_data", int'(bus.rsp_data), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single op: (2, 1, add), consumer always ready
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_a = 6'd2; bus.req0_b = 6'd1; bus.req0_op = 2'b00;
      @(negedge clk);
      chk("single_ready_c0", int'(bus.req0_ready), 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("single_sel_c1", int'({bus.alu_sel1, bus.alu_sel0}), 0);
      @(negedge clk);
      chk("single_rsp_valid_c2", int'(bus.rsp_valid), 1);
      chk("single_rsp_id_c2", int'(bus.rsp_id), 0);
      chk("single_rsp_data_c2", int'(bus.rsp_data), 3);
      @(posedge clk); #1;
      chk("single_done_cnt", int'(bus.done_cnt), 1);

      // contention straight after reset: req0 wins, then req1
      pulse_reset();
      glog.delete(); rlog_id.delete(); rlog_data.delete();
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_a = 6'd2; bus.req0_b = 6'd1; bus.req0_op = 2'b01;
      bus.req1_valid = 1'b1; bus.req1_a = 6'd2; bus.req1_b = 6'd1; bus.req1_op = 2'b10;
      k = 0;
      while ((bus.req0_valid || bus.req1_valid) && k < 50) begin
         @(posedge clk); #1;
         foreach (glog[i]) begin
            if (glog[i] == 0) bus.req0_valid = 1'b0;
            if (glog[i] == 1) bus.req1_valid = 1'b0;
         end
         k++;
      end
      wait_rsps(2, "contention_rsp_timeout");
      chk("contention_grant_count", glog.size(), 2);
      if (glog.size() >= 2) begin
         chk("contention_grant0", glog[0], 0);
         chk("contention_grant1", glog[1], 1);
      end
      if (rlog_id.size() >= 2) begin
         chk("contention_rsp0_id", rlog_id[0], 0);
         chk("contention_rsp0_data", rlog_data[0], 1);
         chk("contention_rsp1_id", rlog_id[1], 1);
         chk("contention_rsp1_data", rlog_data[1], 0);
      end

      // round-robin fairness over 8 ops with both requesters always valid
      glog.delete(); rlog_id.delete(); rlog_data.delete();
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      k = 0;
      while (glog.size() < 8 && k < 100) begin
         @(posedge clk); #1;
         bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_op = 2'($urandom);
         bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_op = 2'($urandom);
         k++;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      wait_rsps(8, "fair_rsp_timeout");
      chk("fair_grant_count", glog.size(), 8);
      cnt0 = 0; cnt1 = 0; alt_ok = 1;
      foreach (glog[i]) begin
         if (glog[i] == 0) cnt0++; else cnt1++;
         if (i > 0 && glog[i] == glog[i-1]) alt_ok = 0;
      end
      chk("fair_alternate", alt_ok, 1);
      chk("fair_count0", cnt0, 4);
      chk("fair_count1", cnt1, 4);

      // backpressure: response held 10 cycles while both requesters wait
      bus.rsp_ready = 1'b0;
      do_op(1'b1, 6'd45, 6'd19, 2'b11);
      k = 0;
      while (!bus.rsp_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("bp_rsp_seen", int'(bus.rsp_valid), 1);
      hold_id = bus.rsp_id; hold_data = bus.rsp_data; cnt_before = cnt_m;
      chk("bp_rsp_data_lit", int'(hold_data), 62);
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid_hold", int'(bus.rsp_valid), 1);
         chk("bp_id_hold", int'(bus.rsp_id), int'(hold_id));
         chk("bp_data_hold", int'(bus.rsp_data), int'(hold_data));
         chk("bp_busy", int'(bus.busy), 1);
         chk("bp_readies", int'({bus.req0_ready, bus.req1_ready}), 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("bp_complete_valid", int'(bus.rsp_valid), 1);
      @(posedge clk); #1;
      chk("bp_done_cnt", int'(bus.done_cnt), int'(cnt_before + 8'd1));
      chk("bp_idle", int'(bus.busy), 0);

      // reset in the middle of EXEC loses the op
      do_op(1'b0, 6'd5, 6'd3, 2'b01);
      chk("mid_exec_busy", int'(bus.busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("mid_rst_done_cnt", int'(bus.done_cnt), 0);
      chk("mid_rst_alu_a", int'(bus.alu_a), 0);
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      rlog_id.delete(); rlog_data.delete();
      do_op(1'b0, 6'd2, 6'd1, 2'b00);
      wait_rsps(1, "post_rst_rsp_timeout");
      if (rlog_id.size() >= 1) begin
         chk("post_rst_rsp_id", rlog_id[0], 0);
         chk("post_rst_rsp_data", rlog_data[0], 3);
      end

      // random traffic until 256 completions since reset, then the counter reads 0
      k = 0;
      while (total_m < 256 && k < 20000) begin
         @(posedge clk); #1;
         bus.req0_valid = ($urandom_range(2) != 0);
         bus.req1_valid = ($urandom_range(2) != 0);
         bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_op = 2'($urandom);
         bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_op = 2'($urandom);
         bus.rsp_ready = ($urandom_range(3) != 0);
         k++;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      chk("wrap_reached", total_m, 256);
      @(negedge clk);
      chk("wrap_done_cnt", int'(bus.done_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
